fp_mult_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 binary floating-point multiplier with

---
 rtl/fp_mult_pkg.sv | 27 ++
 rtl/fp_round_rne.sv | 23 ++
 rtl/fp_mult_pipe.sv | 180 ++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared classes, special-result codes and exponent helpers for fp_mult_pipe
package fp_mult_pkg;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    ZERO = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // special is one-hot {+0,-0,+inf,-inf,NaN}
  localparam logic [4:0] SPECIAL_NONE     = 5'b00000;
  localparam logic [4:0] SPECIAL_POS_ZERO = 5'b10000;
  localparam logic [4:0] SPECIAL_NEG_ZERO = 5'b01000;
  localparam logic [4:0] SPECIAL_POS_INF  = 5'b00100;
  localparam logic [4:0] SPECIAL_NEG_INF  = 5'b00010;
  localparam logic [4:0] SPECIAL_NAN      = 5'b00001;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even of a normalised significand using guard/round/sticky
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]   sig,
  input  logic             guard,
  input  logic             round,
  input  logic             sticky,
  output logic [MAN_W-1:0] frac,
  output logic             carry
);

  logic             up;
  logic [MAN_W+1:0] sum;

  // ties (guard only) round up only when the kept lsb is odd
  assign up    = guard & (round | sticky | sig[0]);
  assign sum   = {1'b0, sig} + {{(MAN_W+1){1'b0}}, up};
  assign carry = sum[MAN_W+1];
  // on carry-out the significand is exactly 10.00..0, so the low bits are already zero
  assign frac  = sum[MAN_W-1:0];

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - pipelined IEEE-754 multiplier with RNE, DAZ/FTZ, specials and tag passthrough
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   data_a,
  input  logic [EXP_W+MAN_W:0]   data_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   data_r,
  output logic [TAG_W-1:0]       out_tag,
  output logic [4:0]             special
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_E    = EW'(bias_of(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX_E = EW'(exp_max_of(EXP_W));

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic                  sign;
    fp_class_e             cls;
    logic signed [EW-1:0]  exp;
  } hdr_t;

  logic stall, en;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  // stage 1: unpack and classify; subnormals count as zero
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  fp_class_e c1;
  logic signed [EW-1:0] exp_sum;

  assign {ea, fa} = data_a[EXP_W+MAN_W-1:0];
  assign {eb, fb} = data_b[EXP_W+MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;

  always_comb begin
    c1 = NORM;
    if (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) c1 = NAN;
    else if (a_inf | b_inf)                                  c1 = INF;
    else if (a_zero | b_zero)                                c1 = ZERO;
  end

  hdr_t hdr1, hdr2, hdr3;
  logic [MAN_W:0] sa1, sb1;
  logic [PW-1:0]  prod, prod2;
  logic [MAN_W:0] sig_n, sig3;
  logic g_n, r_n, s_n, g3, r3, s3;
  logic signed [EW-1:0] exp_n;

  assign prod = {{(PW-MAN_W-1){1'b0}}, sa1} * {{(PW-MAN_W-1){1'b0}}, sb1};

  // stage 3 input: product lies in [1,4); bring it back to [1,2)
  always_comb begin
    sig_n = prod2[PW-2 -: MAN_W+1];
    g_n   = prod2[MAN_W-1];
    r_n   = prod2[MAN_W-2];
    s_n   = |prod2[MAN_W-3:0];
    exp_n = hdr2.exp;
    if (prod2[PW-1]) begin
      sig_n = prod2[PW-1 -: MAN_W+1];
      g_n   = prod2[MAN_W];
      r_n   = prod2[MAN_W-1];
      s_n   = |prod2[MAN_W-2:0];
      exp_n = hdr2.exp + EW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr1  <= '0;
      sa1   <= '0;
      sb1   <= '0;
      hdr2  <= '0;
      prod2 <= '0;
      hdr3  <= '0;
      sig3  <= '0;
      g3    <= 1'b0;
      r3    <= 1'b0;
      s3    <= 1'b0;
    end else if (en) begin
      hdr1  <= '{valid: in_valid, tag: in_tag, sign: data_a[EXP_W+MAN_W] ^ data_b[EXP_W+MAN_W],
                 cls: c1, exp: exp_sum};
      sa1   <= {1'b1, fa};
      sb1   <= {1'b1, fb};
      hdr2  <= hdr1;
      prod2 <= prod;
      hdr3  <= '{valid: hdr2.valid, tag: hdr2.tag, sign: hdr2.sign, cls: hdr2.cls, exp: exp_n};
      sig3  <= sig_n;
      g3    <= g_n;
      r3    <= r_n;
      s3    <= s_n;
    end
  end

  logic [MAN_W-1:0]      frac_r;
  logic                  carry;
  logic signed [EW-1:0]  exp_f;
  logic [EXP_W+MAN_W:0]  r_data;
  logic [4:0]            r_special;

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .sig    (sig3),
    .guard  (g3),
    .round  (r3),
    .sticky (s3),
    .frac   (frac_r),
    .carry  (carry)
  );

  assign exp_f = hdr3.exp + EW'(carry);

  always_comb begin
    r_data    = '0;
    r_special = SPECIAL_NONE;
    case (hdr3.cls)
      NAN: begin
        r_data    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        r_special = SPECIAL_NAN;
      end
      INF: begin
        r_data    = {hdr3.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        r_special = hdr3.sign ? SPECIAL_NEG_INF : SPECIAL_POS_INF;
      end
      ZERO: begin
        r_data    = {hdr3.sign, {(EXP_W+MAN_W){1'b0}}};
        r_special = hdr3.sign ? SPECIAL_NEG_ZERO : SPECIAL_POS_ZERO;
      end
      default: begin
        if (exp_f >= EXP_MAX_E) begin
          r_data    = {hdr3.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          r_special = hdr3.sign ? SPECIAL_NEG_INF : SPECIAL_POS_INF;
        end else if (exp_f[EW-1] || (exp_f == '0)) begin
          r_data    = {hdr3.sign, {(EXP_W+MAN_W){1'b0}}};
          r_special = hdr3.sign ? SPECIAL_NEG_ZERO : SPECIAL_POS_ZERO;
        end else begin
          r_data    = {hdr3.sign, exp_f[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_r    <= '0;
      out_tag   <= '0;
      special   <= '0;
    end else if (en) begin
      out_valid <= hdr3.valid;
      if (hdr3.valid) begin
        data_r  <= r_data;
        out_tag <= hdr3.tag;
        special <= r_special;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - vector table plus scoreboard bench for fp_mult_pipe
module tb_fp_mult_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] data_a, data_b, data_r;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  special;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  sp;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  sp;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_r    (data_r),
    .out_tag   (out_tag),
    .special   (special)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // result monitor: compares each accepted output against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data %h tag %h with empty scoreboard", data_r, out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_r", data_r, e.r);
        check("special", {27'b0, special}, {27'b0, e.sp});
        check("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] er, input logic [4:0] es);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    data_a = a;
    data_b = b;
    in_tag = tag;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      sb.push_back('{r: er, sp: es, tag: tag});
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 30 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] hold_d;
    logic [3:0]  hold_t;
    int n;

    vecs.push_back('{32'h40FC0000, 32'h3E400000, 32'h3FBD0000, 5'b00000});
    vecs.push_back('{32'hC1900000, 32'h41180000, 32'hC32B0000, 5'b00000});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00000});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00100});
    vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 5'b10000});
    vecs.push_back('{32'h00000000, 32'hFF800000, 32'h7FC00000, 5'b00001});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00001});
    vecs.push_back('{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00000});
    vecs.push_back('{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 5'b00000});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00010});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 5'b01000});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 5'b10000});
    vecs.push_back('{32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000});
    vecs.push_back('{32'h3F800000, 32'h7F800001, 32'h7FC00000, 5'b00001});

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    data_a = '0;
    data_b = '0;
    in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 0);
    check("reset_data_r", data_r, 0);
    check("reset_out_tag", {28'b0, out_tag}, 0);
    check("reset_special", {27'b0, special}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 1);

    // latency of a single isolated operation
    issue(vecs[0].a, vecs[0].b, 4'hA, vecs[0].r, vecs[0].sp);
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_cycles", n, 3);
    drain();

    // whole table back to back
    for (int i = 0; i < vecs.size(); i++)
      issue(vecs[i].a, vecs[i].b, 4'(i), vecs[i].r, vecs[i].sp);
    drain();

    // five tagged ops with a 4-cycle consumer stall mid-stream
    fork
      begin
        for (int i = 1; i <= 5; i++)
          issue(vecs[i].a, vecs[i].b, 4'(i), vecs[i].r, vecs[i].sp);
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
          @(posedge clk);
          #1;
          w++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) begin
            hold_d = data_r;
            hold_t = out_tag;
          end
          check("stall_out_valid", {31'b0, out_valid}, 1);
          check("stall_in_ready", {31'b0, in_ready}, 0);
          check("stall_data_r_stable", data_r, hold_d);
          check("stall_out_tag_stable", {28'b0, out_tag}, {28'b0, hold_t});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with two operations in flight
    issue(vecs[1].a, vecs[1].b, 4'h7, vecs[1].r, vecs[1].sp);
    issue(vecs[2].a, vecs[2].b, 4'h8, vecs[2].r, vecs[2].sp);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("reset_async_out_valid", {31'b0, out_valid}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("stale_results_after_reset", n, 0);

    // pipeline still works after reset
    issue(vecs[3].a, vecs[3].b, 4'h3, vecs[3].r, vecs[3].sp);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
